dice_judge: RTL

- Game controller downstream of the dice roller. It consumes the two dice values and drives each player's start level and the global finish flag.
- Player 1 owns die 1 and player 2 owns die 2. Each player holds a debounced key to roll and releases it to stop.
- After both players have rolled, the block compares the frozen values, awards a point and declares a match winner at WIN_SCORE.
- Sits between the debounce stage (key pulses) and the roller (start1/start2/finish); its outputs also feed the display/LED stage.

---
 rtl/dice_judge_pkg.sv | 32 +++
 rtl/dice_compare.sv | 29 ++
 rtl/dice_judge.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dice_judge_pkg.sv
// Shared definitions for the dice game controller and the display stage.
package dice_judge_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WAIT1   = 4'd1,
        S_ROLL1   = 4'd2,
        S_SETTLE1 = 4'd3,
        S_WAIT2   = 4'd4,
        S_ROLL2   = 4'd5,
        S_SETTLE2 = 4'd6,
        S_JUDGE   = 4'd7,
        S_SHOW    = 4'd8,
        S_OVER    = 4'd9
    } state_e;

    // Round result / match winner codes.
    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_P1   = 2'b01,
        RW_P2   = 2'b10,
        RW_TIE  = 2'b11
    } round_e;

    localparam logic [3:0] DIE_MIN = 4'd1;
    localparam logic [3:0] DIE_MAX = 4'd6;

    function automatic logic die_valid(input logic [3:0] v);
        return (v >= DIE_MIN) && (v <= DIE_MAX);
    endfunction

endpackage

// File: rtl/dice_compare.sv
// Rank compare of two die values: a valid face beats an invalid one,
// two invalid faces tie, otherwise the higher face wins.
module dice_compare
    import dice_judge_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [1:0] code_o
);

    logic va, vb;

    // Combinational rank decision.
    always_comb begin
        va     = die_valid(a_i);
        vb     = die_valid(b_i);
        code_o = RW_TIE;
        if (va && vb) begin
            if (a_i > b_i)      code_o = RW_P1;
            else if (a_i < b_i) code_o = RW_P2;
            else                code_o = RW_TIE;
        end else if (va) begin
            code_o = RW_P1;
        end else if (vb) begin
            code_o = RW_P2;
        end
    end

endmodule

// File: rtl/dice_judge.sv
// Two-player dice game controller: sequences each player's roll,
// freezes the dice after the roller has settled, scores the round and
// declares the match winner.
module dice_judge
    import dice_judge_pkg::*;
#(
    parameter int SETTLE_CYC = 110,
    parameter int SHOW_CYC   = 2000,
    parameter int WIN_SCORE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dice1,
    input  logic [3:0] dice2,
    input  logic       k1_press,
    input  logic       k1_rel,
    input  logic       k2_press,
    input  logic       k2_rel,
    output logic       start1,
    output logic       start2,
    output logic       finish,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] round_win,
    output logic [1:0] winner,
    output logic [3:0] state_o
);

    localparam int CNT_MAX = (SETTLE_CYC > SHOW_CYC) ? SETTLE_CYC : SHOW_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST   = CNT_W'(SHOW_CYC - 1);
    localparam logic [3:0]       WIN_PTS     = 4'(WIN_SCORE);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start1_q, start2_q, finish_q;
    logic [3:0]       val1_q, val2_q, score1_q, score2_q;
    logic [1:0]       round_win_q, winner_q;
    logic [3:0]       score1_d, score2_d;
    logic [1:0]       rw;

    dice_compare u_cmp (
        .a_i    (val1_q),
        .b_i    (val2_q),
        .code_o (rw)
    );

    // Saturating next score for whichever player takes the round.
    always_comb begin
        score1_d = (score1_q == 4'hF) ? score1_q : score1_q + 4'd1;
        score2_d = (score2_q == 4'hF) ? score2_q : score2_q + 4'd1;
    end

    // Game FSM with registered outputs and the shared settle/show counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            start1_q    <= 1'b0;
            start2_q    <= 1'b0;
            finish_q    <= 1'b0;
            val1_q      <= '0;
            val2_q      <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            round_win_q <= RW_NONE;
            winner_q    <= RW_NONE;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_WAIT1;
                // Press and release in one cycle is a key glitch, not a roll.
                S_WAIT1: if (k1_press && !k1_rel) begin
                    state_q  <= S_ROLL1;
                    start1_q <= 1'b1;
                end
                S_ROLL1: if (k1_rel) begin
                    state_q  <= S_SETTLE1;
                    start1_q <= 1'b0;
                    cnt_q    <= '0;
                end
                // Wait out one full roller update before trusting the die.
                S_SETTLE1: if (cnt_q == SETTLE_LAST) begin
                    val1_q  <= dice1;
                    state_q <= S_WAIT2;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_WAIT2: if (k2_press && !k2_rel) begin
                    state_q  <= S_ROLL2;
                    start2_q <= 1'b1;
                end
                S_ROLL2: if (k2_rel) begin
                    state_q  <= S_SETTLE2;
                    start2_q <= 1'b0;
                    cnt_q    <= '0;
                end
                S_SETTLE2: if (cnt_q == SETTLE_LAST) begin
                    val2_q  <= dice2;
                    state_q <= S_JUDGE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_JUDGE: begin
                    round_win_q <= rw;
                    if (rw == RW_P1) score1_q <= score1_d;
                    if (rw == RW_P2) score2_q <= score2_d;
                    cnt_q   <= '0;
                    state_q <= S_SHOW;
                end
                // Only one score can move per round, so at most one reaches the target.
                S_SHOW: if (cnt_q == SHOW_LAST) begin
                    if (score1_q >= WIN_PTS) begin
                        winner_q <= RW_P1;
                        finish_q <= 1'b1;
                        state_q  <= S_OVER;
                    end else if (score2_q >= WIN_PTS) begin
                        winner_q <= RW_P2;
                        finish_q <= 1'b1;
                        state_q  <= S_OVER;
                    end else begin
                        state_q <= S_WAIT1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_OVER: if (k1_press || k2_press) begin
                    score1_q    <= '0;
                    score2_q    <= '0;
                    val1_q      <= '0;
                    val2_q      <= '0;
                    round_win_q <= RW_NONE;
                    winner_q    <= RW_NONE;
                    finish_q    <= 1'b0;
                    state_q     <= S_WAIT1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start1    = start1_q;
    assign start2    = start2_q;
    assign finish    = finish_q;
    assign val1      = val1_q;
    assign val2      = val2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign round_win = round_win_q;
    assign winner    = winner_q;
    assign state_o   = state_q;

endmodule
